// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
// Owns the single register-file write port. It arbitrates the ALU (source 0)
// and the load unit (source 1) round-robin and registers the winner onto
// oWrite/oAddrC/oRegC. It also keeps a busy-bit scoreboard that stalls issue
// on RAW and WAW hazards.
//
// Handshake semantics (both writeback sources):
//   A source raises iWbValidN with a stable address and data. It keeps all
//   three stable until a cycle in which oWbReadyN is high. That cycle is the
//   transfer: the request is consumed at the next rising edge. oWbReadyN is
//   combinational, depends only on the valids, the pointer and reset, and is
//   never high in a cycle without the matching valid. At most one of
//   oWbReady0/oWbReady1 is high per cycle.
//   Issue follows the same rule. An instruction is accepted in any cycle
//   where iIssueValid and oIssueReady are both high.
module regfile_wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iIssueValid,
  input  logic [ADDR_W-1:0] iIssueDst,
  input  logic [ADDR_W-1:0] iIssueSrcA,
  input  logic [ADDR_W-1:0] iIssueSrcB,
  output logic              oIssueReady,
  input  logic              iWbValid0,
  input  logic [ADDR_W-1:0] iWbAddr0,
  input  logic [DATA_W-1:0] iWbData0,
  output logic              oWbReady0,
  input  logic              iWbValid1,
  input  logic [ADDR_W-1:0] iWbAddr1,
  input  logic [DATA_W-1:0] iWbData1,
  output logic              oWbReady1,
  output logic              oWrite,
  output logic [ADDR_W-1:0] oAddrC,
  output logic [DATA_W-1:0] oRegC,
  output logic [NREG-1:0]   oBusy
);

  // Scoreboard: bit n is set while a write to register n is outstanding.
  // Bit 0 is never set.
  logic [NREG-1:0]   busy_q, busy_d;
  // Round-robin pointer: 0 favours the ALU, 1 favours the load unit.
  logic              rr_q, rr_d;
  // Registered write port.
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              gnt0, gnt1, any_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              issue_ready, issue_accept;

  // Arbitration: a lone request wins; on contention the pointer decides.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!iRst) begin
      if (iWbValid0 && iWbValid1) begin
        gnt0 = ~rr_q;
        gnt1 = rr_q;
      end else begin
        gnt0 = iWbValid0;
        gnt1 = iWbValid1;
      end
    end
    any_gnt = gnt0 | gnt1;
  end

  // Winner's payload. Data only ever reaches a register, never an output directly.
  always_comb begin
    sel_addr = iWbAddr0;
    sel_data = iWbData0;
    if (gnt1) begin
      sel_addr = iWbAddr1;
      sel_data = iWbData1;
    end
  end

  // Pointer moves away from whoever was just granted; it holds when idle.
  always_comb begin
    rr_d = rr_q;
    if (gnt0) begin
      rr_d = 1'b1;
    end else if (gnt1) begin
      rr_d = 1'b0;
    end
  end

  // Next write-port contents. A grant to r0 is consumed but never written.
  // Address and data hold when there is no grant.
  always_comb begin
    wr_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (any_gnt) begin
      wr_d   = (sel_addr != '0);
      addr_d = sel_addr;
      data_d = sel_data;
    end
  end

  // Issue check uses only registered busy bits.
  // A clear landing this edge is therefore seen one cycle later.
  always_comb begin
    issue_ready  = !iRst
                 && !busy_q[iIssueSrcA]
                 && !busy_q[iIssueSrcB]
                 && !busy_q[iIssueDst];
    issue_accept = iIssueValid && issue_ready;
  end

  // Scoreboard update: clear the register being written this edge, then set
  // the newly issued destination, so a set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_q) begin
      busy_d[addr_q] = 1'b0;
    end
    if (issue_accept && (iIssueDst != '0)) begin
      busy_d[iIssueDst] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers. Reset drops in-flight writes and all busy bits.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      busy_q <= '0;
      rr_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      rr_q   <= rr_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign oIssueReady = issue_ready;
  assign oWbReady0   = gnt0;
  assign oWbReady1   = gnt1;
  assign oWrite      = wr_q;
  assign oAddrC      = addr_q;
  assign oRegC       = data_q;
  assign oBusy       = busy_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus a randomized run,
// each checked against a behavioural model of the scheduler.
module tb_regfile_wb_scheduler;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iIssueValid;
  logic [AW-1:0] iIssueDst, iIssueSrcA, iIssueSrcB;
  logic          oIssueReady;
  logic          iWbValid0, iWbValid1;
  logic [AW-1:0] iWbAddr0, iWbAddr1;
  logic [DW-1:0] iWbData0, iWbData1;
  logic          oWbReady0, oWbReady1;
  logic          oWrite;
  logic [AW-1:0] oAddrC;
  logic [DW-1:0] oRegC;
  logic [NR-1:0] oBusy;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit            m_busy[NR];
  int            m_fav;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  logic [AW+DW-1:0] exp_q[$];

  regfile_wb_scheduler #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR)) dut (
    .iClk(iClk), .iRst(iRst),
    .iIssueValid(iIssueValid), .iIssueDst(iIssueDst),
    .iIssueSrcA(iIssueSrcA), .iIssueSrcB(iIssueSrcB),
    .oIssueReady(oIssueReady),
    .iWbValid0(iWbValid0), .iWbAddr0(iWbAddr0), .iWbData0(iWbData0),
    .oWbReady0(oWbReady0),
    .iWbValid1(iWbValid1), .iWbAddr1(iWbAddr1), .iWbData1(iWbData1),
    .oWbReady1(oWbReady1),
    .oWrite(oWrite), .oAddrC(oAddrC), .oRegC(oRegC), .oBusy(oBusy)
  );

  // Clock
  always #5 iClk = ~iClk;

  // ---------------- model ----------------
  function automatic logic [NR-1:0] m_busy_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    v[0] = 1'b0;
    return v;
  endfunction

  function automatic bit m_is_busy(input logic [AW-1:0] r);
    return (r != 0) && m_busy[r];
  endfunction

  function automatic bit m_ready();
    if (iRst) return 1'b0;
    return !(m_is_busy(iIssueSrcA) || m_is_busy(iIssueSrcB) || m_is_busy(iIssueDst));
  endfunction

  // -1: nobody granted, otherwise the source index.
  function automatic int m_grant();
    if (iRst) return -1;
    if (iWbValid0 && iWbValid1) return m_fav;
    if (iWbValid0) return 0;
    if (iWbValid1) return 1;
    return -1;
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  // Returns at the following falling edge.
  task automatic cycle();
    int            g;
    bit            acc;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    g   = m_grant();
    acc = iIssueValid && m_ready();
    ga  = (g == 1) ? iWbAddr1 : iWbAddr0;
    gd  = (g == 1) ? iWbData1 : iWbData0;
    @(posedge iClk);
    if (iRst) begin
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      m_fav = 0; m_wr = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      if (m_wr) m_busy[m_addr] = 1'b0;
      if (acc && iIssueDst != 0) m_busy[iIssueDst] = 1'b1;
      if (g >= 0) begin
        m_wr = (ga != 0); m_addr = ga; m_data = gd; m_fav = 1 - g;
      end else begin
        m_wr = 1'b0;
      end
    end
    @(negedge iClk);
  endtask

  task automatic clear_inputs();
    iIssueValid = 0; iIssueDst = '0; iIssueSrcA = '0; iIssueSrcB = '0;
    iWbValid0 = 0; iWbAddr0 = '0; iWbData0 = '0;
    iWbValid1 = 0; iWbAddr1 = '0; iWbData1 = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++; if (oWrite !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", oWrite); end
    checks++; if (oBusy !== '0) begin errors++; $display("FAIL reset_busy: got %h expected 0", oBusy); end
    checks++; if (oAddrC !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", oAddrC); end
    for (int i = 0; i < 4; i++) begin
      iIssueDst  = AW'($urandom_range(0, NR-1));
      iIssueSrcA = AW'($urandom_range(0, NR-1));
      iIssueSrcB = AW'($urandom_range(0, NR-1));
      #1;
      checks++; if (oIssueReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", oIssueReady); end
      cycle();
    end
    clear_inputs();
  endtask

  task automatic test_raw_hazard();
    iIssueValid = 1; iIssueDst = 5; iIssueSrcA = 1; iIssueSrcB = 2; #1;
    checks++; if (oIssueReady !== 1'b1) begin errors++; $display("FAIL raw_issue5_ready: got %b expected 1", oIssueReady); end
    cycle();
    iIssueDst = 6; iIssueSrcA = 5; iIssueSrcB = 0;
    iWbValid0 = 1; iWbAddr0 = 5; iWbData0 = 32'hDEADBEEF; #1;
    checks++; if (oBusy[5] !== 1'b1) begin errors++; $display("FAIL raw_busy5_set: got %b expected 1", oBusy[5]); end
    checks++; if (oIssueReady !== 1'b0) begin errors++; $display("FAIL raw_stall: got %b expected 0", oIssueReady); end
    checks++; if (oWbReady0 !== 1'b1) begin errors++; $display("FAIL raw_alu_grant: got %b expected 1", oWbReady0); end
    cycle();
    iWbValid0 = 0; #1;
    checks++; if (oWrite !== 1'b1) begin errors++; $display("FAIL raw_write: got %b expected 1", oWrite); end
    checks++; if (oAddrC !== 5) begin errors++; $display("FAIL raw_addr: got %0d expected 5", oAddrC); end
    checks++; if (oRegC !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_data: got %h expected deadbeef", oRegC); end
    checks++; if (oIssueReady !== 1'b0) begin errors++; $display("FAIL raw_still_stalled: got %b expected 0", oIssueReady); end
    cycle(); #1;
    checks++; if (oBusy[5] !== 1'b0) begin errors++; $display("FAIL raw_busy5_clear: got %b expected 0", oBusy[5]); end
    checks++; if (oIssueReady !== 1'b1) begin errors++; $display("FAIL raw_release: got %b expected 1", oIssueReady); end
    cycle(); iIssueValid = 0; #1;
    checks++; if (oBusy !== m_busy_vec() || oBusy[6] !== 1'b1) begin errors++; $display("FAIL raw_busy6: got %h expected %h", oBusy, m_busy_vec()); end
    iWbValid1 = 1; iWbAddr1 = 6; iWbData1 = 32'h6;
    cycle(); iWbValid1 = 0;
    cycle(); clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [AW+DW-1:0] e;
    iRst = 1; cycle(); iRst = 0;
    iWbValid0 = 1; iWbAddr0 = 3; iWbData0 = 32'h11;
    iWbValid1 = 1; iWbAddr1 = 4; iWbData1 = 32'h22;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (oWbReady0 !== (i % 2 == 0) || oWbReady1 !== (i % 2 == 1))
        begin errors++; $display("FAIL b2b_grant%0d: got %b%b expected source %0d", i, oWbReady1, oWbReady0, i % 2); end
      if (i % 2 == 0) exp_q.push_back({iWbAddr0, iWbData0});
      else            exp_q.push_back({iWbAddr1, iWbData1});
      cycle();
      e = exp_q.pop_front();
      checks++; if (oWrite !== 1'b1 || oAddrC !== e[AW+DW-1:DW] || oRegC !== e[DW-1:0])
        begin errors++; $display("FAIL b2b_write%0d: got %b %0d %h expected 1 %0d %h", i, oWrite, oAddrC, oRegC, e[AW+DW-1:DW], e[DW-1:0]); end
      if (i % 2 == 0) begin iWbAddr0 = iWbAddr0 + 2; iWbData0 = $urandom; end
      else            begin iWbAddr1 = iWbAddr1 + 2; iWbData1 = $urandom; end
    end
    clear_inputs();
  endtask

  task automatic test_r0_write();
    // ALU grant first so the pointer favours the load unit.
    iWbValid0 = 1; iWbAddr0 = 12; iWbData0 = $urandom;
    iIssueValid = 1; iIssueDst = 20;
    cycle();
    clear_inputs();
    iWbValid1 = 1; iWbAddr1 = 0; iWbData1 = 32'hFFFFFFFF; #1;
    checks++; if (oWbReady1 !== 1'b1 || oWbReady0 !== 1'b0) begin errors++; $display("FAIL r0_grant: got %b%b expected 10", oWbReady1, oWbReady0); end
    cycle(); iWbValid1 = 0; #1;
    checks++; if (oWrite !== 1'b0) begin errors++; $display("FAIL r0_no_write: got %b expected 0", oWrite); end
    checks++; if (oBusy !== 32'h0010_0000) begin errors++; $display("FAIL r0_busy: got %h expected 00100000", oBusy); end
    iWbValid0 = 1; iWbAddr0 = 14; iWbValid1 = 1; iWbAddr1 = 15; #1;
    checks++; if (oWbReady0 !== 1'b1 || oWbReady1 !== 1'b0) begin errors++; $display("FAIL r0_ptr_moved: got %b%b expected 01", oWbReady1, oWbReady0); end
    cycle(); iWbValid0 = 0; #1;
    checks++; if (oWbReady1 !== 1'b1) begin errors++; $display("FAIL r0_load_next: got %b expected 1", oWbReady1); end
    cycle(); iWbValid1 = 0;
    iWbValid0 = 1; iWbAddr0 = 20; cycle(); iWbValid0 = 0;
    cycle(); #1;
    checks++; if (oBusy !== '0) begin errors++; $display("FAIL r0_cleanup_busy: got %h expected 0", oBusy); end
    clear_inputs();
  endtask

  task automatic test_same_edge();
    int g;
    iIssueValid = 1; iIssueDst = 7; iIssueSrcA = 1; iIssueSrcB = 2;
    cycle();
    iIssueValid = 0; iWbValid0 = 1; iWbAddr0 = 7; iWbData0 = $urandom; #1;
    checks++; if (oBusy[7] !== 1'b1) begin errors++; $display("FAIL same_busy7: got %b expected 1", oBusy[7]); end
    cycle();
    iWbValid0 = 0; iIssueValid = 1; #1;
    checks++; if (oWrite !== 1'b1 || oAddrC !== 7) begin errors++; $display("FAIL same_write7: got %b %0d expected 1 7", oWrite, oAddrC); end
    checks++; if (oIssueReady !== 1'b0) begin errors++; $display("FAIL same_edge_stall: got %b expected 0", oIssueReady); end
    cycle(); #1;
    checks++; if (oBusy[7] !== 1'b0 || oIssueReady !== 1'b1) begin errors++; $display("FAIL same_retry: got busy %b ready %b expected 0 1", oBusy[7], oIssueReady); end
    cycle(); iIssueValid = 0; #1;
    checks++; if (oBusy[7] !== 1'b1) begin errors++; $display("FAIL same_reissue_busy7: got %b expected 1", oBusy[7]); end
    // Write to a non-busy r8 while issuing Dst=8 on its clear edge: set wins.
    iWbValid1 = 1; iWbAddr1 = 8; iWbData1 = $urandom;
    cycle();
    iWbValid1 = 0; iIssueValid = 1; iIssueDst = 8; iIssueSrcA = 0; iIssueSrcB = 0; #1;
    checks++; if (oIssueReady !== 1'b1 || oWrite !== 1'b1) begin errors++; $display("FAIL same_r8_ready: got %b %b expected 1 1", oIssueReady, oWrite); end
    cycle(); iIssueValid = 0; #1;
    checks++; if (oBusy[8] !== 1'b1) begin errors++; $display("FAIL same_set_wins: got %b expected 1", oBusy[8]); end
    iWbValid0 = 1; iWbAddr0 = 7; iWbValid1 = 1; iWbAddr1 = 8;
    for (int i = 0; i < 2; i++) begin
      g = m_grant(); cycle();
      if (g == 0) iWbValid0 = 0;
      if (g == 1) iWbValid1 = 0;
    end
    cycle(); #1;
    checks++; if (oBusy !== '0) begin errors++; $display("FAIL same_cleanup_busy: got %h expected 0", oBusy); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    iWbValid0 = 1; iWbAddr0 = 13; iWbData0 = $urandom;
    cycle();
    iWbValid0 = 0; iIssueValid = 1; iIssueDst = 9;
    cycle();
    iIssueValid = 0; iWbValid0 = 1; iWbAddr0 = 9; iWbData0 = $urandom; #1;
    checks++; if (oBusy[9] !== 1'b1 || oWbReady0 !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got busy %b gnt %b expected 1 1", oBusy[9], oWbReady0); end
    iRst = 1; #1;
    checks++; if (oWbReady0 !== 1'b0 || oIssueReady !== 1'b0) begin errors++; $display("FAIL rstmid_forced: got %b %b expected 0 0", oWbReady0, oIssueReady); end
    cycle();
    iRst = 0; iWbValid0 = 0; #1;
    checks++; if (oWrite !== 1'b0 || oBusy !== '0) begin errors++; $display("FAIL rstmid_state: got %b %h expected 0 0", oWrite, oBusy); end
    iWbValid0 = 1; iWbAddr0 = 10; iWbValid1 = 1; iWbAddr1 = 11; #1;
    checks++; if (oWbReady0 !== 1'b1 || oWbReady1 !== 1'b0) begin errors++; $display("FAIL rstmid_ptr: got %b%b expected 01", oWbReady1, oWbReady0); end
    cycle(); iWbValid0 = 0;
    cycle(); iWbValid1 = 0;
    cycle();
    clear_inputs();
  endtask

  task automatic test_random();
    int g;
    for (int n = 0; n < 400; n++) begin
      iRst = ($urandom_range(0, 99) == 0);
      if (!iWbValid0 && $urandom_range(0, 99) < 50) begin
        iWbValid0 = 1; iWbAddr0 = AW'($urandom_range(0, 7)); iWbData0 = $urandom;
      end
      if (!iWbValid1 && $urandom_range(0, 99) < 50) begin
        iWbValid1 = 1; iWbAddr1 = AW'($urandom_range(0, 7)); iWbData1 = $urandom;
      end
      iIssueValid = ($urandom_range(0, 99) < 40);
      iIssueDst   = AW'($urandom_range(0, 7));
      iIssueSrcA  = AW'($urandom_range(0, 9));
      iIssueSrcB  = AW'($urandom_range(0, 9));
      #1;
      checks++; if (oIssueReady !== m_ready()) begin errors++; $display("FAIL rnd_ready @%0d: got %b expected %b", n, oIssueReady, m_ready()); end
      checks++; if (oWbReady0 !== (m_grant() == 0) || oWbReady1 !== (m_grant() == 1))
        begin errors++; $display("FAIL rnd_grant @%0d: got %b%b expected source %0d", n, oWbReady1, oWbReady0, m_grant()); end
      checks++; if (oWrite !== m_wr || oAddrC !== m_addr || oRegC !== m_data)
        begin errors++; $display("FAIL rnd_wport @%0d: got %b %0d %h expected %b %0d %h", n, oWrite, oAddrC, oRegC, m_wr, m_addr, m_data); end
      checks++; if (oBusy !== m_busy_vec()) begin errors++; $display("FAIL rnd_busy @%0d: got %h expected %h", n, oBusy, m_busy_vec()); end
      g = m_grant();
      cycle();
      if (g == 0) iWbValid0 = 0;
      if (g == 1) iWbValid1 = 0;
    end
    iRst = 0;
    clear_inputs();
  endtask

  // Watchdog
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    clear_inputs();
    iRst = 1;
    cycle();
    cycle();
    iRst = 0;
    test_reset();
    test_raw_hazard();
    test_back_to_back();
    test_r0_write();
    test_same_edge();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
